// File: rtl/vector_register_file_param.sv
// vector_register_file_param
//   Scalar + vector register file for the decode stage. Two banks share one
//   index space; the address MSB picks the bank (1 = vector, 0 = scalar).
//   Entry 0 of each bank always reads zero and ignores writes. After reset
//   a sequencer walks every index and zeroes both banks (busy=1 meanwhile,
//   external writes ignored, reads return zero).
//
//   Optional feature macro: RF_BYPASS_EN -- same-cycle write-through
//   forwarding from the write port to either read port.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   WE3          write enable
//   WM3[LANES]   per-lane write mask (vector bank only)
//   A1, A2       combinational read addresses
//   A3           write address
//   WD3[DW]      write data
//   RD1, RD2     read data (scalar entries zero-extended)
//   busy         high while the clear sequence runs

// One lane of the vector bank: 2**IDX_W x LANE_W storage, 1W2R.
module vrf_lane #(
  parameter int LANE_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LANE_W-1:0] wd,
  input  logic [IDX_W-1:0]  ridx1,
  input  logic [IDX_W-1:0]  ridx2,
  output logic [LANE_W-1:0] rd1,
  output logic [LANE_W-1:0] rd2
);
  logic [LANE_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk)
    if (we) mem[widx] <= wd;

  assign rd1 = mem[ridx1];
  assign rd2 = mem[ridx2];
endmodule

module vector_register_file_param #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int IDX_W  = 5,
  localparam int DW    = LANES*LANE_W,
  localparam int AW    = IDX_W+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE3,
  input  logic [LANES-1:0] WM3,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  input  logic [AW-1:0]    A3,
  input  logic [DW-1:0]    WD3,
  output logic [DW-1:0]    RD1,
  output logic [DW-1:0]    RD2,
  output logic             busy
);
  localparam int NENT = 2**IDX_W;

  typedef enum logic {CLEAR, IDLE} state_t;
  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr;

  // state register (clear pointer advances only while clearing)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // next state: leave CLEAR after the last index has been zeroed
  always_comb begin
    state_nx = state;
    if (state == CLEAR && ptr == {IDX_W{1'b1}}) state_nx = IDLE;
  end

  // outputs
  always_comb begin
    busy = (state == CLEAR);
  end

  // ---- write side: the clear sequencer borrows the write port ----
  logic                          wr_ok, s_we;
  logic [IDX_W-1:0]              widx;
  logic [LANES-1:0]              l_we;
  logic [LANES-1:0][LANE_W-1:0]  l_wd, rd1_v, rd2_v;
  logic [LANE_W-1:0]             smem [NENT];

  assign wr_ok = !busy && WE3 && (A3[IDX_W-1:0] != '0);
  assign widx  = busy ? ptr : A3[IDX_W-1:0];
  assign s_we  = busy || (wr_ok && !A3[AW-1]);

  always_ff @(posedge clk)
    if (s_we) smem[widx] <= busy ? '0 : WD3[LANE_W-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign l_we[i] = busy || (wr_ok && A3[AW-1] && WM3[i]);
    assign l_wd[i] = busy ? '0 : WD3[i*LANE_W +: LANE_W];

    vrf_lane #(.LANE_W(LANE_W), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (l_we[i]),
      .widx  (widx),
      .wd    (l_wd[i]),
      .ridx1 (A1[IDX_W-1:0]),
      .ridx2 (A2[IDX_W-1:0]),
      .rd1   (rd1_v[i]),
      .rd2   (rd2_v[i])
    );
  end

  // ---- read side ----
  logic hit1, hit2;
`ifdef RF_BYPASS_EN
  // wr_ok already excludes index 0 and the clear phase
  assign hit1 = wr_ok && (A1 == A3);
  assign hit2 = wr_ok && (A2 == A3);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Bank select, zero-index/busy masking and optional forwarding merge.
  function automatic logic [DW-1:0] rd_sel(
    input logic [AW-1:0]     a,
    input logic [DW-1:0]     vraw,
    input logic [LANE_W-1:0] sraw,
    input logic              hit,
    input logic              blank,
    input logic [LANES-1:0]  wm,
    input logic [DW-1:0]     wd
  );
    logic [DW-1:0] r;
    r = '0;
    if (blank || a[IDX_W-1:0] == '0) begin
      r = '0;
    end else if (a[AW-1]) begin
      r = vraw;
      if (hit)
        for (int i = 0; i < LANES; i++)
          if (wm[i]) r[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    end else begin
      r[LANE_W-1:0] = hit ? wd[LANE_W-1:0] : sraw;
    end
    return r;
  endfunction

  assign RD1 = rd_sel(A1, rd1_v, smem[A1[IDX_W-1:0]], hit1, busy, WM3, WD3);
  assign RD2 = rd_sel(A2, rd2_v, smem[A2[IDX_W-1:0]], hit2, busy, WM3, WD3);
endmodule

// File: tb/tb_vector_register_file_param.sv
module tb_vector_register_file_param;
  localparam int LANES = 4, LANE_W = 32, IDX_W = 5;
  localparam int DW = LANES*LANE_W, AW = IDX_W+1;

  logic             clk = 1'b0;
  logic             rst;
  logic             WE3;
  logic [LANES-1:0] WM3;
  logic [AW-1:0]    A1, A2, A3;
  logic [DW-1:0]    WD3;
  logic [DW-1:0]    RD1, RD2;
  logic             busy;

  vector_register_file_param #(.LANES(LANES), .LANE_W(LANE_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .WE3(WE3), .WM3(WM3), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .RD1(RD1), .RD2(RD2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [DW-1:0] e1, e2;
    logic          eb;
  } exp_t;

  exp_t q[$];
  logic chk = 1'b0;
  int   n_chk = 0, n_fail = 0;

  // monitor: a check is presented by raising chk; compare on the falling edge
  always @(negedge clk) begin
    if (chk) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: output presented with no expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (RD1 !== e.e1 || RD2 !== e.e2 || busy !== e.eb) begin
          n_fail++;
          $display("FAIL %s: got RD1=%h RD2=%h busy=%b, want RD1=%h RD2=%h busy=%b",
                   e.nm, RD1, RD2, busy, e.e1, e.e2, e.eb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    chk = 1'b0;
  endtask

  task automatic expect_rd(input string nm, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic eb);
    exp_t e;
    e.nm = nm; e.e1 = e1; e.e2 = e2; e.eb = eb;
    q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [DW-1:0] d);
    WE3 = 1'b1; A3 = a; WM3 = m; WD3 = d;
    tick();
    WE3 = 1'b0;
  endtask

  // Clear phase: busy must stay high exactly NENT cycles with reads forced to 0,
  // while a write attempt to 0x21 is held on the port the whole time.
  task automatic clear_phase(input string nm);
    for (int k = 0; k < 2**IDX_W; k++) begin
      WE3 = 1'b1; A3 = 6'h21; WM3 = 4'hF; WD3 = '1;
      A1 = 6'h3E; A2 = 6'h1F;
      expect_rd(nm, '0, '0, 1'b1);
      tick();
    end
    WE3 = 1'b0;
    A1 = 6'h00; A2 = 6'h00;
    expect_rd({nm, "_done"}, '0, '0, 1'b0);
    tick();
  endtask

  task automatic all_zero(input string nm);
    for (int a = 0; a < 2**AW; a++) begin
      A1 = a[AW-1:0]; A2 = 6'(63 - a);
      expect_rd(nm, '0, '0, 1'b0);
      tick();
    end
  endtask

  localparam logic [DW-1:0] V2 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [DW-1:0] V3 = 128'h44444444_AAAAAAAA_22222222_AAAAAAAA;
  localparam logic [DW-1:0] V5 = 128'h44444444_AAAAAAAA_BBBBBBBB_AAAAAAAA;

  initial begin
    rst = 1'b0; WE3 = 1'b0; WM3 = '0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

    // 1. reset held 3 cycles, then clear
    tick();
    A1 = 6'h23; A2 = 6'h05;
    expect_rd("in_reset", '0, '0, 1'b1);
    tick(); tick();
    rst = 1'b1;
    clear_phase("clear1");
    all_zero("post_clear1");

    // 2. vector full write
    wr(6'h23, 4'hF, V2);
    A1 = 6'h23; A2 = 6'h03;
    expect_rd("vec_full", V2, '0, 1'b0);
    tick();

    // 3. masked lanes, then an all-zero mask
    wr(6'h23, 4'b0101, {4{32'hAAAAAAAA}});
    A1 = 6'h23; A2 = 6'h23;
    expect_rd("vec_masked_same_addr", V3, V3, 1'b0);
    tick();
    wr(6'h23, 4'h0, '1);
    A1 = 6'h23; A2 = 6'h03;
    expect_rd("vec_mask_zero", V3, '0, 1'b0);
    tick();

    // 4. scalar write (upper WD3 and WM3 ignored), zero registers
    wr(6'h05, 4'h0, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF});
    A1 = 6'h05; A2 = 6'h25;
    expect_rd("scalar_zext", {96'h0, 32'hDEADBEEF}, '0, 1'b0);
    tick();
    wr(6'h00, 4'hF, '1);
    wr(6'h20, 4'hF, '1);
    A1 = 6'h00; A2 = 6'h20;
    expect_rd("zero_regs", '0, '0, 1'b0);
    tick();

    // 5. bypass, scalar then vector, then index 0
    wr(6'h07, 4'h0, {96'h0, 32'h11111111});
    WE3 = 1'b1; A3 = 6'h07; WM3 = 4'h0; WD3 = {96'h0, 32'h12345678};
    A1 = 6'h07; A2 = 6'h05;
`ifdef RF_BYPASS_EN
    expect_rd("byp_scalar_same", {96'h0, 32'h12345678}, {96'h0, 32'hDEADBEEF}, 1'b0);
`else
    expect_rd("byp_scalar_same", {96'h0, 32'h11111111}, {96'h0, 32'hDEADBEEF}, 1'b0);
`endif
    tick();
    WE3 = 1'b0;
    expect_rd("byp_scalar_next", {96'h0, 32'h12345678}, {96'h0, 32'hDEADBEEF}, 1'b0);
    tick();

    WE3 = 1'b1; A3 = 6'h23; WM3 = 4'b0010; WD3 = {4{32'hBBBBBBBB}};
    A1 = 6'h03; A2 = 6'h23;
`ifdef RF_BYPASS_EN
    expect_rd("byp_vec_same", '0, V5, 1'b0);
`else
    expect_rd("byp_vec_same", '0, V3, 1'b0);
`endif
    tick();
    WE3 = 1'b0;
    expect_rd("byp_vec_next", '0, V5, 1'b0);
    tick();

    WE3 = 1'b1; A3 = 6'h20; WM3 = 4'hF; WD3 = '1;
    A1 = 6'h20; A2 = 6'h20;
    expect_rd("byp_index0", '0, '0, 1'b0);
    tick();
    WE3 = 1'b0;

    // populate high indices so the second clear has something to erase
    wr(6'h3E, 4'hF, {4{32'hC0FFEE00}});
    wr(6'h1F, 4'h0, {96'h0, 32'h0BADF00D});
    A1 = 6'h3E; A2 = 6'h1F;
    expect_rd("high_entries", {4{32'hC0FFEE00}}, {96'h0, 32'h0BADF00D}, 1'b0);
    tick();

    // 6. reset, abort the clear at cycle 10 with another reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      A1 = 6'h3E; A2 = 6'h1F;
      expect_rd("clear_partial", '0, '0, 1'b1);
      tick();
    end
    rst = 1'b0;
    expect_rd("midclear_reset", '0, '0, 1'b1);
    tick();
    rst = 1'b1;
    clear_phase("clear2");
    all_zero("post_clear2");

    tick(); tick();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_register_file_param.md
Name: vector_register_file_param

Overview:
Parametrised successor to the processor's scalar/vector register file. It has two banks: a scalar bank of LANE_W-bit registers and a vector bank of LANES×LANE_W-bit registers. It provides two combinational read ports, one synchronous write port with a per-lane write mask, entry 0 of each bank hardwired to zero, and a post-reset clear sequencer that zeroes both banks. It sits in the decode stage, between decode/control (RegWriteD → WE3) and the execute-stage operand muxes.

Parameters:
LANES, 4, number of vector lanes
LANE_W, 32, bits per lane; scalar register width
IDX_W, 5, register index width; each bank holds 2**IDX_W entries
(derived) DW = LANES*LANE_W, data width; AW = IDX_W+1, address width; address MSB selects the bank (1 = vector, 0 = scalar)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
WE3  in  1  write enable (from RegWriteD)
WM3  in  LANES  per-lane write mask; vector bank only
A1  in  AW  read address, port 1
A2  in  AW  read address, port 2
A3  in  AW  write address
WD3  in  DW  write data
RD1  out  DW  read data, port 1
RD2  out  DW  read data, port 2
busy  out  1  high while the clear sequence runs

Behaviour:
- Reset (rst=0, asynchronous): state←CLEAR, clear pointer ptr←0, busy←1.
  - The arrays themselves are not asynchronously reset.
  - RD1/RD2 read 0 while busy=1.
- FSM states: CLEAR, IDLE.
  - CLEAR: every cycle writes 0 to scalar[ptr] and vector[ptr], then ptr←ptr+1.
  - When ptr == 2**IDX_W-1 that entry is cleared and state→IDLE; busy=0 on the following cycle.
  - Clear takes exactly 2**IDX_W cycles after rst deasserts (32 by default).
  - rst asserted mid-clear restarts the sequence at ptr=0.
  - IDLE: stays in IDLE until the next reset.
- Writes in CLEAR: WE3 is ignored; no external write is performed.
- Write (IDLE, WE3=1, A3[IDX_W-1:0]≠0), at the rising edge:
  - Vector bank (A3 MSB=1): for each lane i with WM3[i]=1, lane i ← WD3[i*LANE_W +: LANE_W]. Unmasked lanes hold their value. WM3=0 means no change.
  - Scalar bank (A3 MSB=0): entry ← WD3[LANE_W-1:0]. WM3 is ignored.
  - Writes to index 0 of either bank are discarded.
- Read (combinational, zero latency):
  - Vector address: full DW-bit entry.
  - Scalar address: {zeros, scalar entry}, i.e. zero-extended to DW.
  - Index 0 of either bank always reads 0.
- Simultaneous events:
  - A1 == A2 is legal; both ports return identical data.
  - Read and write of the same address in the same cycle: governed by RF_BYPASS_EN (see below).
- No X propagation: any address returns a defined value once clear completes.

Optional Feature:
RF_BYPASS_EN
- Defined: write-through forwarding. If IDLE, WE3=1, a read address equals A3 and the index is ≠0, that RD port returns the post-write value in the same cycle:
  - Vector: masked merge of WD3 with the stored entry.
  - Scalar: zero-extended WD3[LANE_W-1:0].
- Undefined: a same-cycle read returns the old stored value; the new value appears the cycle after the edge.

Test Plan:
1. Reset and clear: assert rst=0 for 3 cycles, then release → busy=1 for exactly 32 cycles then 0; every scalar and vector address reads 0; WE3=1 to A3=6'h21 during clear leaves entry 0x21 = 0.
2. Vector full write: WE3=1, A3=6'h23, WM3=4'hF, WD3=128'h44444444_33333333_22222222_11111111 → next cycle A1=6'h23 reads that value; A2=6'h03 reads 0.
3. Masked lanes: after scenario 2, WM3=4'b0101, WD3=all 0xAAAAAAAA → entry 0x23 reads 128'h44444444_AAAAAAAA_22222222_AAAAAAAA.
4. Scalar and zero register: write 32'hDEADBEEF to A3=6'h05 → RD1 reads 128'h0…DEADBEEF; write 0xFFFFFFFF to A3=6'h00 and A3=6'h20 → both still read 0.
5. Bypass: A1=A3=6'h07, WE3=1, WD3[31:0]=0x12345678 → with RF_BYPASS_EN, RD1 shows 0x12345678 in the same cycle; without it, RD1 shows the old value, then 0x12345678 the next cycle.
6. Reset mid-clear: pulse rst=0 at clear cycle 10 → busy stays 1 for 32 further cycles after release; all entries read 0 afterwards.
